// File: rtl/ftdi_tx.sv
// ftdi_tx: FT245 sync-FIFO transmit engine, buffered 32-bit words out MSB-first.
// Define FTDI_TX_SIWU_EN to pulse SIWU# for one cycle after each packet's last word.
module ftdi_tx #(
  parameter int FIFO_AW = 3
) (
  input  logic        ft_clk,
  input  logic        reset_n,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  input  logic        ft_txe,
  output logic        ft_wr,
  output logic        ft_rd,
  output logic        ft_oe,
  output logic [7:0]  ft_data_out,
  output logic        ft_data_oe,
  output logic        ft_siwu,
  output logic        tx_busy,
  output logic [15:0] tx_byte_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
`ifdef FTDI_TX_SIWU_EN
  localparam bit SIWU_EN = 1'b1;
`else
  localparam bit SIWU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  logic [32:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] lvl_q;
  state_t           state_q;
  logic [31:0]      shreg_q;
  logic             last_q;
  logic [1:0]       bidx_q;
  logic [15:0]      cnt_q;
  logic             siwu_q;

  logic        push, pop, accept, empty, flush_go;
  logic [32:0] head;
  logic [31:0] shifted;

  assign empty      = (lvl_q == '0);
  assign word_ready = (lvl_q < (FIFO_AW+1)'(DEPTH));
  assign push       = word_valid & word_ready;
  assign head       = mem_q[rptr_q];
  assign accept     = (state_q == SEND) & ~ft_txe;
  assign flush_go   = SIWU_EN & last_q;
  assign shifted    = {shreg_q[23:0], 8'h00};

  // Word boundary pops the next entry in the same edge, so words stream gap-free.
  assign pop = ~empty & ((state_q == IDLE) | (state_q == FLUSH)
             | (accept & (bidx_q == 2'd3) & ~flush_go));

  always_ff @(posedge ft_clk) begin
    if (push) mem_q[wptr_q] <= {word_last, word_data};
  end

  always_ff @(posedge ft_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      lvl_q   <= '0;
      state_q <= IDLE;
      shreg_q <= '0;
      last_q  <= 1'b0;
      bidx_q  <= 2'd0;
      cnt_q   <= 16'd0;
      siwu_q  <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      lvl_q  <= lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      siwu_q <= 1'b1;
      if (accept) cnt_q <= cnt_q + 16'd1;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= head[31:0];
            last_q  <= head[32];
            bidx_q  <= 2'd0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (bidx_q != 2'd3) begin
              bidx_q  <= bidx_q + 2'd1;
              shreg_q <= shifted;
            end else if (flush_go) begin
              shreg_q <= shifted;
              siwu_q  <= 1'b0;
              state_q <= FLUSH;
            end else if (pop) begin
              shreg_q <= head[31:0];
              last_q  <= head[32];
              bidx_q  <= 2'd0;
            end else begin
              shreg_q <= shifted;
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (pop) begin
            shreg_q <= head[31:0];
            last_q  <= head[32];
            bidx_q  <= 2'd0;
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ft_wr       = ~accept;
  assign ft_rd       = 1'b1;
  assign ft_oe       = 1'b1;
  assign ft_data_out = shreg_q[31:24];
  assign ft_data_oe  = (state_q == SEND);
  assign ft_siwu     = siwu_q;
  assign tx_busy     = (state_q != IDLE) | ~empty;
  assign tx_byte_cnt = cnt_q;

endmodule

// File: tb/tb_ftdi_tx.sv
// tb_ftdi_tx: scoreboard bench for ftdi_tx; byte monitor decoupled from stimulus.
// Flush expectations follow FTDI_TX_SIWU_EN.
module tb_ftdi_tx;

  logic        ft_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        ft_txe = 1'b1;
  logic        word_ready, ft_wr, ft_rd, ft_oe, ft_data_oe, ft_siwu, tx_busy;
  logic [7:0]  ft_data_out;
  logic [15:0] tx_byte_cnt;

  ftdi_tx #(.FIFO_AW(3)) dut (
    .ft_clk(ft_clk), .reset_n(reset_n),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .ft_txe(ft_txe), .ft_wr(ft_wr),
    .ft_rd(ft_rd), .ft_oe(ft_oe), .ft_data_out(ft_data_out),
    .ft_data_oe(ft_data_oe), .ft_siwu(ft_siwu),
    .tx_busy(tx_busy), .tx_byte_cnt(tx_byte_cnt)
  );

  always #5 ft_clk = ~ft_clk;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: a byte is written at the next rising edge whenever WR# is low.
  always @(negedge ft_clk) begin
    logic [7:0] e;
    if (reset_n && ft_wr === 1'b0) begin
      acc_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL byte_unexpected got=%0h exp=none", ft_data_out);
      end else begin
        e = exp_q.pop_front();
        if (ft_data_out !== e) begin
          fails++;
          $display("FAIL byte_order got=%0h exp=%0h", ft_data_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge ft_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    n = 0;
    @(negedge ft_clk);
    while (!word_ready && n < 100) begin
      @(negedge ft_clk);
      n++;
    end
    if (!word_ready) begin
      check("push_timeout", 32'(word_ready), 32'd1);
      word_valid = 1'b0;
    end else begin
      step();
      word_valid = 1'b0;
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    int gaps;
    int acc0;
    bit wr_low, siwu_low;

    repeat (3) step();
    check("rst_wr", ft_wr, 1);
    check("rst_siwu", ft_siwu, 1);
    check("rst_data", ft_data_out, 8'h00);
    check("rst_oe", ft_data_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", word_ready, 1);
    check("rst_cnt", tx_byte_cnt, 0);
    check("rst_rd_oe", {ft_rd, ft_oe}, 2'b11);
    reset_n = 1'b1;
    step();

    // Single word with first-byte latency
    ft_txe = 1'b0;
    push(32'h11223344, 1'b0);
    @(negedge ft_clk);
    check("lat_idle_wr", ft_wr, 1);
    @(negedge ft_clk);
    check("lat_send_wr", ft_wr, 0);
    check("lat_send_oe", ft_data_oe, 1);
    repeat (6) step();
    check("single_cnt", tx_byte_cnt, 4);
    check("single_busy", tx_busy, 0);
    check("single_q", exp_q.size(), 0);

    // Backpressure after the first byte
    push(32'hA1B2C3D4, 1'b0);
    step();
    step();
    ft_txe = 1'b1;
    repeat (3) begin
      @(negedge ft_clk);
      check("bp_wr", ft_wr, 1);
      check("bp_hold", ft_data_out, 8'hB2);
    end
    step();
    ft_txe = 1'b0;
    drain("bp_drain");
    check("bp_cnt", tx_byte_cnt, 8);

    // Fill: one word in the shifter, eight in the buffer, tenth blocked
    ft_txe = 1'b1;
    for (int i = 0; i < 9; i++)
      push(32'h10203040 + 32'(i) * 32'h01010101, 1'b0);
    @(negedge ft_clk);
    check("fill_ready", word_ready, 0);
    check("fill_busy", tx_busy, 1);
    word_valid = 1'b1;
    word_data  = 32'hDEADBEEF;
    repeat (4) step();
    word_valid = 1'b0;
    ft_txe = 1'b0;
    gaps = 0;
    repeat (36) begin
      @(negedge ft_clk);
      if (ft_wr !== 1'b0) gaps++;
    end
    check("fill_gaps", gaps, 0);
    drain("fill_drain");
    check("fill_cnt", tx_byte_cnt, 44);

    // Packet end: flush bubble with SIWU# only when the feature is built in
    push(32'h01020304, 1'b1);
    push(32'h05060708, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge ft_clk);
`ifdef FTDI_TX_SIWU_EN
      wr_low   = (k <= 3) || (k >= 5 && k <= 8);
      siwu_low = (k == 4);
`else
      wr_low   = (k <= 7);
      siwu_low = 1'b0;
`endif
      check("flush_wr", ft_wr, !wr_low);
      check("flush_siwu", ft_siwu, !siwu_low);
    end
    drain("flush_drain");
    check("flush_cnt", tx_byte_cnt, 52);

    // Reset mid-word after two bytes
    push(32'hCAFEBABE, 1'b0);
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr", ft_wr, 1);
    check("mid_rst_oe", ft_data_oe, 0);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_cnt", tx_byte_cnt, 0);
    check("mid_rst_q", exp_q.size(), 2);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    acc0 = acc_cnt;
    repeat (8) step();
    check("post_rst_stale", acc_cnt - acc0, 0);
    check("post_rst_ready", word_ready, 1);

    // Counter wrap: exactly 65536 accepted bytes
    acc0 = acc_cnt;
    for (int i = 0; i < 16384; i++)
      push({16'(i), ~16'(i)}, 1'b0);
    drain("wrap_drain");
    check("wrap_bytes", acc_cnt - acc0, 65536);
    check("wrap_cnt", tx_byte_cnt, 0);
    check("wrap_busy", tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
